seg7_scan_capture: RTL

//  Reverse path of our HEX display chain. Samples a time-multiplexed, active-low
//  7-segment bus (segment lines plus per-digit anode selects) driven by an external

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seg7_scan_capture.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the HEX display chain (forward and readback paths).
// Patterns are active-low, index 0 = segment a ... index 6 = segment g.
package seg7_pkg;

    typedef logic [0:6] seg_pat_t;

    localparam seg_pat_t SEG_0     = 7'b0000001;
    localparam seg_pat_t SEG_1     = 7'b1001111;
    localparam seg_pat_t SEG_2     = 7'b0010010;
    localparam seg_pat_t SEG_3     = 7'b0000110;
    localparam seg_pat_t SEG_4     = 7'b1001100;
    localparam seg_pat_t SEG_5     = 7'b0100100;
    localparam seg_pat_t SEG_6     = 7'b0100000;
    localparam seg_pat_t SEG_7     = 7'b0001111;
    localparam seg_pat_t SEG_8     = 7'b0000000;
    localparam seg_pat_t SEG_9     = 7'b0000100;
    localparam seg_pat_t SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the HEX segment encoder: pattern -> {ok, code}.
// Any pattern outside the digit/blank table reports ok=0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [0:6] pat,
    output logic       ok,
    output logic [3:0] code
);

    always_comb begin
        ok   = 1'b1;
        code = 4'h0;
        case (pat)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                ok   = 1'b0;
                code = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Readback of a scanned active-low 7-segment display: synchronise, wait for the
// anode select to settle, sample once per dwell, and commit digits after repeated agreement.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int SETTLE = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:6]        seg_n,
    input  logic [NDIG-1:0]   an_n,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   digit_vld,
    output logic [NDIG-1:0]   digit_err,
    output logic              upd,
    output logic              sel_err
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int SW = $clog2(STABLE + 1);
    localparam int LW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE);
    localparam logic [CW-1:0] SAMPLE_AT  = CW'(SETTLE - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE);

    logic [0:6]      seg_s1, seg_s2;
    logic [NDIG-1:0] an_s1, an_s2, an_prev;
    logic [CW-1:0]   settle_cnt;
    logic            an_changed;
    logic            sample_pt;
    logic [LW-1:0]   low_cnt;
    logic [NDIG-1:0] strobe;
    logic            sel_hit;
    logic            dec_ok;
    logic [3:0]      dec_code;
    logic [NDIG-1:0] upd_hit;

    // Two-flop synchronisers; idle (all 1s) is the inactive level for both buses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            an_s1  <= an_n;
            an_s2  <= an_s1;
        end
    end

    assign an_changed = (an_s2 != an_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_prev    <= '1;
            settle_cnt <= '0;
        end else begin
            an_prev <= an_s2;
            if (an_changed)
                settle_cnt <= '0;
            else if (settle_cnt != SETTLE_MAX)
                settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // The counter passes SETTLE-1 exactly once per dwell, so this fires at most once.
    assign sample_pt = !an_changed && (settle_cnt == SAMPLE_AT);

    always_comb begin
        low_cnt = '0;
        for (int i = 0; i < NDIG; i++)
            low_cnt = low_cnt + LW'(!an_s2[i]);
    end

    assign strobe  = (sample_pt && low_cnt == LW'(1)) ? ~an_s2 : '0;
    assign sel_hit = sample_pt && (low_cnt > LW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
            upd     <= 1'b0;
        end else begin
            sel_err <= sel_hit;
            upd     <= |upd_hit;
        end
    end

    seg7_pattern_decode u_decode (
        .pat  (seg_s2),
        .ok   (dec_ok),
        .code (dec_code)
    );

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        logic [3:0]    cand;
        logic [SW-1:0] stab;
        logic [SW-1:0] stab_nxt;
        logic [3:0]    dig_q;
        logic          vld_q;
        logic          err_q;
        logic          commit;

        always_comb begin
            stab_nxt = SW'(1);
            if (dec_code == cand)
                stab_nxt = (stab == STABLE_MAX) ? stab : stab + 1'b1;
        end

        assign commit      = strobe[gi] && dec_ok && (stab_nxt == STABLE_MAX);
        // Re-commits of an unchanged value stay silent.
        assign upd_hit[gi] = commit && (!vld_q || dig_q != dec_code);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cand  <= '0;
                stab  <= '0;
                dig_q <= '0;
                vld_q <= 1'b0;
                err_q <= 1'b0;
            end else if (strobe[gi]) begin
                if (!dec_ok) begin
                    err_q <= 1'b1;
                    stab  <= '0;
                end else begin
                    err_q <= 1'b0;
                    cand  <= dec_code;
                    stab  <= stab_nxt;
                    if (commit) begin
                        dig_q <= dec_code;
                        vld_q <= 1'b1;
                    end
                end
            end
        end

        assign digits[4*gi +: 4] = dig_q;
        assign digit_vld[gi]     = vld_q;
        assign digit_err[gi]     = err_q;
    end

endmodule
